// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared defaults and helpers for the baud tick generator
package baud_pkg;

    localparam int DEF_DIV_W      = 16;
    localparam int DEF_FRAC_W     = 4;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DIV        = 651;

    // Ceiling log2, usable in constant expressions; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/baud_frac_divider.sv
// rtl/baud_frac_divider.sv - fractional clock divider emitting oversample events
module baud_frac_divider
    import baud_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int FRAC_W      = DEF_FRAC_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en,
    input  logic              resync,
    input  logic              div_wr,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [FRAC_W-1:0] frac_in,
    output logic              os_evt,
    output logic              cfg_err
);

    logic [DIV_W-1:0]  div_r;
    logic [FRAC_W-1:0] frac_r;
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;

    logic              wr_ok;
    logic [FRAC_W:0]   acc_sum;
    logic              carry;
    logic [DIV_W-1:0]  reload;

    // Divisors below 2 cannot produce a distinct tick cycle, so they are refused.
    assign wr_ok   = div_wr && (div_in >= DIV_W'(2));
    assign acc_sum = {1'b0, acc} + {1'b0, frac_r};
    assign carry   = acc_sum[FRAC_W];
    // A carry stretches the next period by one clock (div_r - 1 + carry).
    assign reload  = carry ? div_r : (div_r - DIV_W'(1));
    // An event fires on the enabled edge that finds the counter exhausted.
    assign os_evt  = en && !resync && (cnt == '0);

    // Divisor registers, down-counter and fractional accumulator.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            div_r   <= DIV_W'(DEFAULT_DIV);
            frac_r  <= '0;
            cnt     <= DIV_W'(DEFAULT_DIV - 1);
            acc     <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= div_wr && !wr_ok;
            if (wr_ok) begin
                div_r  <= div_in;
                frac_r <= frac_in;
            end
            if (resync) begin
                // A divisor written alongside resync takes effect on this period.
                cnt <= wr_ok ? (div_in - DIV_W'(1)) : (div_r - DIV_W'(1));
                acc <= '0;
            end else if (en) begin
                if (cnt != '0) begin
                    cnt <= cnt - DIV_W'(1);
                end else begin
                    acc <= acc_sum[FRAC_W-1:0];
                    cnt <= reload;
                end
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversample, bit-centre and bit-end tick generator
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int FRAC_W      = DEF_FRAC_W,
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              en,
    input  logic              resync,
    input  logic              div_wr,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [FRAC_W-1:0] frac_in,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              baud_tick,
    output logic              cfg_err
);

    localparam int SUB_W = clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0] SUB_MID_PRE = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(OVERSAMPLE - 1);

    logic             os_evt;
    logic [SUB_W-1:0] sub;

    baud_frac_divider #(
        .DIV_W       (DIV_W),
        .FRAC_W      (FRAC_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .resync  (resync),
        .div_wr  (div_wr),
        .div_in  (div_in),
        .frac_in (frac_in),
        .os_evt  (os_evt),
        .cfg_err (cfg_err)
    );

    // Phase counter within a bit and registered tick pulses derived from it.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sub       <= '0;
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else if (resync) begin
            sub       <= '0;
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else begin
            os_tick   <= os_evt;
            mid_tick  <= os_evt && (sub == SUB_MID_PRE);
            baud_tick <= os_evt && (sub == SUB_LAST);
            if (os_evt) begin
                // OVERSAMPLE is a power of two, so natural wrap gives the modulo.
                sub <= sub + SUB_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - directed self-checking bench for baud_tick_gen
module tb_baud_tick_gen;

    logic        clk_in;
    logic        rst_n;
    logic        en;
    logic        resync;
    logic        div_wr;
    logic [15:0] div_in;
    logic [3:0]  frac_in;
    logic        os_tick;
    logic        mid_tick;
    logic        baud_tick;
    logic        cfg_err;

    int cyc;
    int n_checks;
    int n_fail;

    baud_tick_gen dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .resync    (resync),
        .div_wr    (div_wr),
        .div_in    (div_in),
        .frac_in   (frac_in),
        .os_tick   (os_tick),
        .mid_tick  (mid_tick),
        .baud_tick (baud_tick),
        .cfg_err   (cfg_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // which: 0 = os_tick, 1 = mid_tick, 2 = baud_tick; t = -1 on timeout
    task automatic wait_sig(input int which, input int budget, output int t);
        logic s;
        t = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk_in);
            s = (which == 0) ? os_tick : (which == 1) ? mid_tick : baud_tick;
            if (s === 1'b1) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset;
        int c0;
        int t0;
        int t1;
        @(negedge clk_in);
        rst_n = 1'b0;
        en    = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (os_tick !== 1'b0) begin n_fail++; $display("FAIL reset_os_tick: got %b want 0", os_tick); end
        n_checks++;
        if (mid_tick !== 1'b0) begin n_fail++; $display("FAIL reset_mid_tick: got %b want 0", mid_tick); end
        n_checks++;
        if (baud_tick !== 1'b0) begin n_fail++; $display("FAIL reset_baud_tick: got %b want 0", baud_tick); end
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        rst_n = 1'b1;
        c0 = cyc;
        wait_sig(0, 700, t0);
        n_checks++;
        if (t0 - c0 !== 651) begin n_fail++; $display("FAIL reset_first_os: got %0d edges want 651", t0 - c0); end
        wait_sig(0, 700, t1);
        n_checks++;
        if (t1 - t0 !== 651) begin n_fail++; $display("FAIL os_spacing: got %0d want 651", t1 - t0); end
    endtask

    task automatic test_default_ticks;
        int tb1;
        int tm;
        int tb2;
        wait_sig(2, 10500, tb1);
        wait_sig(1, 5300, tm);
        n_checks++;
        if (tb1 < 0 || tm - tb1 !== 5208) begin n_fail++; $display("FAIL mid_after_baud: got %0d want 5208", tm - tb1); end
        wait_sig(2, 5300, tb2);
        n_checks++;
        if (tb1 < 0 || tb2 - tb1 !== 10416) begin n_fail++; $display("FAIL baud_spacing: got %0d want 10416", tb2 - tb1); end
    endtask

    task automatic test_frac;
        int t[17];
        int sum;
        int n652;
        int p;
        @(negedge clk_in);
        resync  = 1'b1;
        div_wr  = 1'b1;
        div_in  = 16'd651;
        frac_in = 4'd1;
        @(negedge clk_in);
        resync  = 1'b0;
        div_wr  = 1'b0;
        for (int i = 0; i < 17; i++) wait_sig(0, 700, t[i]);
        sum  = 0;
        n652 = 0;
        for (int i = 0; i < 16; i++) begin
            p = t[i+1] - t[i];
            sum += p;
            if (p == 652) n652++;
        end
        n_checks++;
        if (t[0] < 0 || sum !== 10417) begin n_fail++; $display("FAIL frac_sum16: got %0d want 10417", sum); end
        n_checks++;
        if (n652 !== 1) begin n_fail++; $display("FAIL frac_n652: got %0d want 1", n652); end
        n_checks++;
        if (t[16] - t[15] !== 652) begin n_fail++; $display("FAIL frac_carry_period: got %0d want 652", t[16] - t[15]); end
        @(negedge clk_in);
        resync  = 1'b1;
        div_wr  = 1'b1;
        div_in  = 16'd651;
        frac_in = 4'd0;
        @(negedge clk_in);
        resync  = 1'b0;
        div_wr  = 1'b0;
    endtask

    task automatic test_cfg_err;
        int t[5];
        int bad;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            div_wr  = 1'b1;
            div_in  = 16'(k);
            frac_in = 4'd5;
            @(negedge clk_in);
            div_wr  = 1'b0;
            n_checks++;
            if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_pulse_div%0d: got %b want 1", k, cfg_err); end
            @(negedge clk_in);
            n_checks++;
            if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_single_div%0d: got %b want 0", k, cfg_err); end
        end
        for (int i = 0; i < 5; i++) wait_sig(0, 700, t[i]);
        bad = 0;
        for (int i = 0; i < 4; i++) if (t[i+1] - t[i] != 651) bad++;
        n_checks++;
        if (t[0] < 0 || bad !== 0) begin n_fail++; $display("FAIL cfg_err_spacing: got %0d bad periods want 0", bad); end
    endtask

    task automatic test_resync;
        int t0;
        int r;
        int tm;
        int tb;
        wait_sig(0, 700, t0);
        repeat (200) @(negedge clk_in);
        resync = 1'b1;
        r = cyc + 1;
        @(negedge clk_in);
        resync = 1'b0;
        n_checks++;
        if ({os_tick, mid_tick, baud_tick} !== 3'b000) begin
            n_fail++;
            $display("FAIL resync_ticks_low: got %b want 000", {os_tick, mid_tick, baud_tick});
        end
        wait_sig(1, 5300, tm);
        n_checks++;
        if (tm - r !== 5208) begin n_fail++; $display("FAIL resync_mid: got %0d want 5208", tm - r); end
        wait_sig(2, 5300, tb);
        n_checks++;
        if (tb - r !== 10416) begin n_fail++; $display("FAIL resync_baud: got %0d want 10416", tb - r); end
    endtask

    task automatic test_en_gap;
        int t0;
        int t1;
        int seen;
        wait_sig(0, 700, t0);
        repeat (300) @(negedge clk_in);
        en   = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (os_tick !== 1'b0 || mid_tick !== 1'b0 || baud_tick !== 1'b0) seen++;
        end
        en = 1'b1;
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL en_gap_ticks: got %0d tick cycles want 0", seen); end
        wait_sig(0, 800, t1);
        n_checks++;
        if (t0 < 0 || t1 - t0 !== 751) begin n_fail++; $display("FAIL en_gap_period: got %0d want 751", t1 - t0); end
    endtask

    task automatic test_reset_mid;
        int c0;
        int t0;
        int t1;
        @(negedge clk_in);
        div_wr = 1'b1;
        div_in = 16'd100;
        @(negedge clk_in);
        div_wr = 1'b0;
        repeat (50) @(negedge clk_in);
        rst_n = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if ({os_tick, mid_tick, baud_tick, cfg_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b want 0000", {os_tick, mid_tick, baud_tick, cfg_err});
        end
        rst_n = 1'b1;
        c0 = cyc;
        wait_sig(0, 700, t0);
        n_checks++;
        if (t0 - c0 !== 651) begin n_fail++; $display("FAIL reset_mid_first_os: got %0d want 651", t0 - c0); end
        wait_sig(0, 700, t1);
        n_checks++;
        if (t0 < 0 || t1 - t0 !== 651) begin n_fail++; $display("FAIL reset_mid_spacing: got %0d want 651", t1 - t0); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        resync   = 1'b0;
        div_wr   = 1'b0;
        div_in   = 16'd651;
        frac_in  = 4'd0;
        repeat (2) @(negedge clk_in);
        test_reset();
        test_default_ticks();
        test_frac();
        test_cfg_err();
        test_resync();
        test_en_gap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
